ah_n2w_packet_arbiter: RTL and testbench

// - Shares one narrow-to-wide packet converter between NREQ narrow requesters.
// - Grants are packet-atomic: the winner owns the converter input for exactly BEATS narrow beats, which is one full wide word.
// - Sits directly upstream of the converter; tags each beat with its source index so downstream logic can route the wide result.
// - Round-robin fairness; no requester starves while others keep presenting traffic.

---
 rtl/ah_n2w_packet_arbiter.sv | 110 +++++++++++
 tb/tb_ah_n2w_packet_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ah_n2w_packet_arbiter.sv
// ah_n2w_packet_arbiter
// Shares one narrow-to-wide converter between NREQ narrow requesters. The
// arbiter locks onto one requester for a whole wide packet of BEATS narrow beats,
// then releases. Round-robin priority starts at the requester after the last owner.
// Each beat carries its source index, so downstream logic can route the wide result.
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous reset, active high
//   req_valid   per-requester beat valid             [NREQ]
//   req_data    requester i beat at [i*DW +: DW]     [NREQ*DW]
//   req_ready   per-requester accept, at most one set [NREQ]
//   conv_valid  beat valid to converter
//   conv_data   beat to converter                    [DW]
//   conv_ready  converter accepts beat
//   conv_src    index of current owner (0 when idle) [SW]
//   conv_last   current beat closes the wide packet
//   busy        a grant is held
module ah_n2w_packet_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DW    = 20,
    parameter int unsigned BEATS = 2,
    parameter int unsigned SW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              conv_valid,
    output logic [DW-1:0]     conv_data,
    input  logic              conv_ready,
    output logic [SW-1:0]     conv_src,
    output logic              conv_last,
    output logic              busy
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e        state;
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] owner;
    logic [CW-1:0] beat_cnt;

    logic          any_valid;
    logic [SW-1:0] winner;
    int unsigned   idx;

    // First valid requester scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                winner    = SW'(idx);
            end
        end
    end

    // Outputs are forced quiet while rst is high, so a reset mid-packet
    // never lets a stray handshake through.
    assign busy       = (state == StLocked) && !rst;
    assign conv_valid = busy && req_valid[owner];
    assign conv_data  = busy ? req_data[int'(owner)*DW +: DW] : '0;
    assign conv_src   = busy ? owner : '0;
    assign conv_last  = busy && (beat_cnt == CW'(BEATS - 1));

    always_comb begin
        req_ready = '0;
        if (busy) begin
            req_ready[owner] = conv_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (any_valid) begin
                        state    <= StLocked;
                        owner    <= winner;
                        beat_cnt <= '0;
                    end
                end
                StLocked: begin
                    if (conv_valid && conv_ready) begin
                        if (conv_last) begin
                            state    <= StIdle;
                            beat_cnt <= '0;
                            rr_ptr   <= (owner == SW'(NREQ - 1)) ? '0 : owner + 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ah_n2w_packet_arbiter.sv
// Directed bench for ah_n2w_packet_arbiter (NREQ=4, DW=20, BEATS=2).
module tb_ah_n2w_packet_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned DW    = 20;
    localparam int unsigned BEATS = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              conv_valid;
    logic [DW-1:0]     conv_data;
    logic              conv_ready;
    logic [1:0]        conv_src;
    logic              conv_last;
    logic              busy;

    int checks = 0;
    int errors = 0;

    ah_n2w_packet_arbiter #(
        .NREQ  (NREQ),
        .DW    (DW),
        .BEATS (BEATS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .conv_valid (conv_valid),
        .conv_data  (conv_data),
        .conv_ready (conv_ready),
        .conv_src   (conv_src),
        .conv_last  (conv_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 2 time units after the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] d);
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        int nb;
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        conv_ready = 1'b1;
        cyc();
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_conv_valid", 32'(conv_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_conv_src", 32'(conv_src), 32'd0);
        chk("rst_conv_last", 32'(conv_last), 32'd0);

        // 1: single requester 0, two-beat packet.
        rst       = 1'b0;
        req_valid = 4'b0001;
        set_data(0, 20'hA0000);
        #1;
        chk("t1_c0_busy", 32'(busy), 32'd0);
        chk("t1_c0_ready", 32'(req_ready), 32'd0);
        cyc();
        chk("t1_c1_busy", 32'(busy), 32'd1);
        chk("t1_c1_src", 32'(conv_src), 32'd0);
        chk("t1_c1_valid", 32'(conv_valid), 32'd1);
        chk("t1_c1_data", 32'(conv_data), 32'hA0000);
        chk("t1_c1_last", 32'(conv_last), 32'd0);
        chk("t1_c1_ready", 32'(req_ready), 32'b0001);
        cyc();
        set_data(0, 20'hA0001);
        #1;
        chk("t1_c2_last", 32'(conv_last), 32'd1);
        chk("t1_c2_data", 32'(conv_data), 32'hA0001);
        chk("t1_c2_ready", 32'(req_ready), 32'b0001);
        cyc();
        chk("t1_c3_busy", 32'(busy), 32'd0);
        chk("t1_c3_valid", 32'(conv_valid), 32'd0);
        chk("t1_c3_ready", 32'(req_ready), 32'd0);

        // 2: all requesters valid from a fresh reset -> owners 0,1,2,3,0.
        rst = 1'b1;
        cyc();
        rst       = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 20'hB0000 | 20'(i));
        #1;
        for (int p = 0; p < 5; p++) begin
            chk("t2_idle_busy", 32'(busy), 32'd0);
            cyc();
            chk("t2_b0_src", 32'(conv_src), 32'(p % 4));
            chk("t2_b0_last", 32'(conv_last), 32'd0);
            chk("t2_b0_ready", 32'(req_ready), 32'(1 << (p % 4)));
            chk("t2_b0_data", 32'(conv_data), 32'h000B0000 | 32'(p % 4));
            cyc();
            chk("t2_b1_src", 32'(conv_src), 32'(p % 4));
            chk("t2_b1_last", 32'(conv_last), 32'd1);
            cyc();
        end
        // rr_ptr is now 1.

        // 3: owner 2 stalls its valid for 5 cycles while requester 1 waits.
        req_valid = 4'b0100;
        set_data(2, 20'hC0000);
        set_data(1, 20'hC1000);
        cyc();
        chk("t3_grant_src", 32'(conv_src), 32'd2);
        chk("t3_b0_data", 32'(conv_data), 32'hC0000);
        cyc();
        req_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_hold_busy", 32'(busy), 32'd1);
            chk("t3_hold_src", 32'(conv_src), 32'd2);
            chk("t3_hold_ready", 32'(req_ready), 32'b0100);
            chk("t3_hold_valid", 32'(conv_valid), 32'd0);
            cyc();
        end
        req_valid = 4'b0110;
        set_data(2, 20'hC0001);
        #1;
        chk("t3_b1_valid", 32'(conv_valid), 32'd1);
        chk("t3_b1_last", 32'(conv_last), 32'd1);
        chk("t3_b1_data", 32'(conv_data), 32'hC0001);
        cyc();
        req_valid = 4'b0010;
        #1;
        chk("t3_idle_busy", 32'(busy), 32'd0);
        cyc();
        // rr_ptr=3: scan 3,0,1 finds requester 1.
        chk("t3_next_src", 32'(conv_src), 32'd1);
        cyc();
        cyc();
        // rr_ptr is now 2.

        // 4: converter stall mid-packet.
        req_valid = 4'b0001;
        set_data(0, 20'hD0000);
        #1;
        chk("t4_idle_busy", 32'(busy), 32'd0);
        cyc();
        chk("t4_grant_src", 32'(conv_src), 32'd0);
        conv_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_stall_ready", 32'(req_ready), 32'd0);
            chk("t4_stall_last", 32'(conv_last), 32'd0);
            chk("t4_stall_data", 32'(conv_data), 32'hD0000);
            cyc();
        end
        conv_ready = 1'b1;
        #1;
        chk("t4_resume_ready", 32'(req_ready), 32'b0001);
        chk("t4_resume_last", 32'(conv_last), 32'd0);
        cyc();
        set_data(0, 20'hD0001);
        #1;
        chk("t4_b1_last", 32'(conv_last), 32'd1);
        chk("t4_b1_data", 32'(conv_data), 32'hD0001);
        cyc();
        req_valid = 4'b0000;
        #1;
        chk("t4_end_busy", 32'(busy), 32'd0);
        // rr_ptr is now 1.

        // 5: reset during beat 1 of owner 3; re-arbitration restarts at 0.
        req_valid = 4'b1000;
        cyc();
        chk("t5_grant_src", 32'(conv_src), 32'd3);
        cyc();
        chk("t5_b1_last", 32'(conv_last), 32'd1);
        rst       = 1'b1;
        req_valid = 4'b1001;
        cyc();
        rst = 1'b0;
        #1;
        chk("t5_post_busy", 32'(busy), 32'd0);
        chk("t5_post_valid", 32'(conv_valid), 32'd0);
        cyc();
        // From rr_ptr=0 requester 0 wins; a kept pointer of 1 would pick 3.
        chk("t5_regrant_src", 32'(conv_src), 32'd0);

        // 6: random traffic; one-hot ready and exact packet length.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        nb  = 0;
        for (int k = 0; k < 400; k++) begin
            req_valid  = 4'($urandom);
            conv_ready = 1'($urandom);
            req_data   = {$urandom, $urandom, $urandom};
            #1;
            chk("t6_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (conv_valid && conv_ready) begin
                if (conv_last) begin
                    chk("t6_pkt_len", 32'(nb + 1), 32'(BEATS));
                    nb = 0;
                end else begin
                    nb++;
                end
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
